// File: rtl/mag_comp1_if.sv
// -----------------------------------------------------------------------------
// mag_comp1_if
//   Operand/result bundle for the registered magnitude comparator.
//
//   Handshake: valid-only, no backpressure. The master presents A, B,
//   casc_gt and casc_lt together with in_valid. The slave samples them on
//   every rising clock edge where in_valid = 1, and never stalls.
//   out_valid rises after the first accepted sample. It then stays high
//   until reset, and the result flags hold their value between samples.
//
//   Signals
//     A, B        operands, WIDTH bits              (master -> slave)
//     in_valid    sample operands this cycle        (master -> slave)
//     casc_gt     cascade: lower stage says greater (master -> slave)
//     casc_lt     cascade: lower stage says less    (master -> slave)
//     bothEqual   registered A == B                 (slave -> master)
//     A_greater   registered A > B                  (slave -> master)
//     B_greater   registered B > A                  (slave -> master)
//     out_valid   flags hold a sampled result       (slave -> master)
// -----------------------------------------------------------------------------
interface mag_comp1_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             in_valid;
  logic             casc_gt;
  logic             casc_lt;
  logic             bothEqual;
  logic             A_greater;
  logic             B_greater;
  logic             out_valid;

  modport master (
    output A, B, in_valid, casc_gt, casc_lt,
    input  bothEqual, A_greater, B_greater, out_valid
  );

  modport slave (
    input  A, B, in_valid, casc_gt, casc_lt,
    output bothEqual, A_greater, B_greater, out_valid
  );
endinterface

// File: rtl/mag_comp1.sv
// -----------------------------------------------------------------------------
// mag_comp1
//   Registered magnitude comparator with 7485-style cascade inputs. It
//   compares A and B as unsigned values, or as two's-complement values when
//   SIGNED = 1. One cycle after a valid sample it reports exactly one of
//   bothEqual, A_greater or B_greater.
//
//   Parameters
//     WIDTH   operand width in bits (>= 1)
//     SIGNED  0 = unsigned compare, 1 = two's-complement compare
//
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset; clears all flags and out_valid
//     bus     mag_comp1_if slave modport (operands, cascade, results)
//
//   To chain stages, connect a less-significant stage's A_greater and
//   B_greater to the next stage's casc_gt and casc_lt. Each stage adds one
//   cycle of latency. Only the most-significant stage may be SIGNED.
// -----------------------------------------------------------------------------
module mag_comp1 #(
  parameter int WIDTH  = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  mag_comp1_if.slave  bus
);

  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  logic             local_gt;
  logic             local_lt;

  logic eq_d, gt_d, lt_d;
  logic eq_q, gt_q, lt_q;
  logic out_valid_q;

  assign a_w = bus.A;
  assign b_w = bus.B;

  // Local relational compare. With WIDTH = 1 and SIGNED = 1, the value 1
  // reads as -1.
  always_comb begin
    local_gt = 1'b0;
    local_lt = 1'b0;
    if (SIGNED) begin
      local_gt = $signed(a_w) > $signed(b_w);
      local_lt = $signed(a_w) < $signed(b_w);
    end else begin
      local_gt = a_w > b_w;
      local_lt = a_w < b_w;
    end
  end

  // The local result decides first. The cascade is consulted only when the
  // operands are equal, and casc_gt beats casc_lt. This keeps the next-state
  // flags one-hot for every input combination.
  always_comb begin
    gt_d = 1'b0;
    lt_d = 1'b0;
    eq_d = 1'b0;
    if (local_gt) begin
      gt_d = 1'b1;
    end else if (local_lt) begin
      lt_d = 1'b1;
    end else if (bus.casc_gt) begin
      gt_d = 1'b1;
    end else if (bus.casc_lt) begin
      lt_d = 1'b1;
    end else begin
      eq_d = 1'b1;
    end
  end

  // Results load only on accepted samples. Idle cycles hold the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      eq_q        <= eq_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      out_valid_q <= 1'b1;
    end
  end

  assign bus.bothEqual = eq_q;
  assign bus.A_greater = gt_q;
  assign bus.B_greater = lt_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mag_comp1.sv
module tb_mag_comp1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main 1-bit unsigned DUT, plus width/sign variants.
  mag_comp1_if #(.WIDTH(1)) if0 ();
  mag_comp1_if #(.WIDTH(1)) ifs1 ();
  mag_comp1_if #(.WIDTH(4)) ifs4 ();
  mag_comp1_if #(.WIDTH(4)) ifu4 ();

  mag_comp1 #(.WIDTH(1), .SIGNED(1'b0)) dut     (.clk(clk), .rst_n(rst_n), .bus(if0));
  mag_comp1 #(.WIDTH(1), .SIGNED(1'b1)) dut_s1  (.clk(clk), .rst_n(rst_n), .bus(ifs1));
  mag_comp1 #(.WIDTH(4), .SIGNED(1'b1)) dut_s4  (.clk(clk), .rst_n(rst_n), .bus(ifs4));
  mag_comp1 #(.WIDTH(4), .SIGNED(1'b0)) dut_u4  (.clk(clk), .rst_n(rst_n), .bus(ifu4));

  // ---------------- scoreboard ----------------
  // Encoding: {out_valid, bothEqual, A_greater, B_greater}
  logic [3:0] exp_q[$];
  logic [3:0] last_exp;
  int checks;
  int failures;

  typedef struct {
    logic       a;
    logic       b;
    logic       gt;
    logic       lt;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [3:0] outs0();
    return {if0.out_valid, if0.bothEqual, if0.A_greater, if0.B_greater};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (ov,eq,agt,bgt)", name, act, exp);
    end
  endtask

  task automatic check_onehot(input string name);
    logic [2:0] f;
    f = {if0.bothEqual, if0.A_greater, if0.B_greater};
    checks++;
    if (!$onehot(f)) begin
      failures++;
      $display("FAIL %s_onehot: flags %b expected exactly one set", name, f);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle(input logic a, input logic b);
    @(negedge clk);
    if0.A = a; if0.B = b; if0.casc_gt = 1'b0; if0.casc_lt = 1'b0;
    if0.in_valid = 1'b0;
  endtask

  // Drives one valid sample and pushes its expected result. On the next
  // edge it pops the entry and compares it with the DUT outputs.
  task automatic apply_vec(input vec_t v);
    logic [3:0] e;
    @(negedge clk);
    if0.A = v.a; if0.B = v.b; if0.casc_gt = v.gt; if0.casc_lt = v.lt;
    if0.in_valid = 1'b1;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got %b expected an entry", v.name, outs0());
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check(v.name, outs0(), e);
      check_onehot(v.name);
    end
    if0.in_valid = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    checks   = 0;
    failures = 0;
    last_exp = 4'b0000;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, "sweep_00"};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, "sweep_01"};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, "sweep_10"};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b1100, "sweep_11"};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b1010, "casc_gt"};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b1001, "casc_lt"};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b1010, "casc_both"};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, "local_wins"};

    rst_n = 1'b1;
    if0.A = '0;  if0.B = '0;  if0.in_valid = 1'b0;  if0.casc_gt = 1'b0;  if0.casc_lt = 1'b0;
    ifs1.A = '0; ifs1.B = '0; ifs1.in_valid = 1'b0; ifs1.casc_gt = 1'b0; ifs1.casc_lt = 1'b0;
    ifs4.A = '0; ifs4.B = '0; ifs4.in_valid = 1'b0; ifs4.casc_gt = 1'b0; ifs4.casc_lt = 1'b0;
    ifu4.A = '0; ifu4.B = '0; ifu4.in_valid = 1'b0; ifu4.casc_gt = 1'b0; ifu4.casc_lt = 1'b0;

    // Reset asserted before the first clock edge (edge at t=5), so the
    // outputs can only clear through the asynchronous path.
    #2 rst_n = 1'b0;
    #1 check("async_reset_initial", outs0(), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_idle(1'b1, 1'b0);
      @(posedge clk);
      #1 check("idle_after_reset", outs0(), 4'b0000);
    end

    // Table-driven sweep plus cascade cases.
    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Hold: the last vector left A_greater set. New operands without
    // in_valid must not change it.
    for (int i = 0; i < 4; i++) begin
      drive_idle(1'b0, 1'b1);
      @(posedge clk);
      #1 check("hold_idle", outs0(), last_exp);
    end

    // Signed/width variants, all sampled in the same cycle.
    @(negedge clk);
    ifs1.A = 1'b1;  ifs1.B = 1'b0;  ifs1.in_valid = 1'b1;
    ifs4.A = 4'hF;  ifs4.B = 4'h1;  ifs4.in_valid = 1'b1;
    ifu4.A = 4'hF;  ifu4.B = 4'h1;  ifu4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("signed_w1", {ifs1.out_valid, ifs1.bothEqual, ifs1.A_greater, ifs1.B_greater}, 4'b1001);
    check("signed_w4", {ifs4.out_valid, ifs4.bothEqual, ifs4.A_greater, ifs4.B_greater}, 4'b1001);
    check("unsigned_w4", {ifu4.out_valid, ifu4.bothEqual, ifu4.A_greater, ifu4.B_greater}, 4'b1010);
    ifs1.in_valid = 1'b0; ifs4.in_valid = 1'b0; ifu4.in_valid = 1'b0;

    // Async reset between edges while A_greater is set.
    apply_vec(vecs[2]);
    #2 rst_n = 1'b0;
    #1 check("async_reset_midstream", outs0(), 4'b0000);
    check("async_reset_w4", {ifu4.out_valid, ifu4.bothEqual, ifu4.A_greater, ifu4.B_greater}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_reset_idle", outs0(), 4'b0000);
    apply_vec(vecs[1]);
    apply_vec(vecs[0]);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mag_comp1.md
# mag_comp1

Registered magnitude comparator: compares two unsigned (or, by parameter, two's-complement) operands A and B and reports exactly one of equal / A greater / B greater. The default build is a 1-bit comparator. Cascade inputs let several instances chain into a wider comparator, in the style of a 7485. It sits in the datapath wherever a one-hot relational flag is needed one cycle after operands are presented.

## Interface
- WIDTH, 1, operand width in bits (legal ≥ 1)
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- in_valid  input  1  operands (and cascade inputs) sampled this cycle
- casc_gt  input  1  cascade "lower stage says greater"; tie 0 when standalone
- casc_lt  input  1  cascade "lower stage says less"; tie 0 when standalone
- bothEqual  output  1  registered: A == B (after cascade resolution)
- A_greater  output  1  registered: A > B
- B_greater  output  1  registered: B > A
- out_valid  output  1  registered: result flags correspond to a sampled operand pair

## Operation
- Compare A with B as unsigned when SIGNED=0, or as two's-complement when SIGNED=1. With WIDTH=1 and SIGNED=1, the value 1 means −1.
- Resolution order, evaluated on the same cycle's inputs:
  - A > B: A_greater = 1.
  - A < B: B_greater = 1.
  - A == B and casc_gt = 1: A_greater = 1.
  - A == B, casc_gt = 0 and casc_lt = 1: B_greater = 1.
  - A == B, casc_gt = 0 and casc_lt = 0: bothEqual = 1.
- casc_gt takes priority over casc_lt if both are asserted. Neither case is an error.
- Once out_valid has been asserted, the three flags are one-hot, and they stay one-hot until the next reset.
- A cycle with in_valid = 0 leaves all flags and out_valid unchanged. The last result holds indefinitely.
- Pure combinational compare feeding one register stage; no FSM.
- Chaining: connect a less-significant stage's A_greater/B_greater to the next stage's casc_gt/casc_lt. Each stage adds one cycle of latency, so the integrator must pipeline-align operands. Only the most-significant stage may use SIGNED=1.

## Timing
- Latency: 1 cycle. Inputs sampled at rising edge N with in_valid = 1 give results on the flags and out_valid = 1 after edge N.
- out_valid stays 1 after the first valid sample. It drops to 0 only on reset.
- Throughput: one compare per cycle, no backpressure.
- Reset: while rst_n = 0, and immediately on its falling edge (asynchronous), bothEqual = 0, A_greater = 0, B_greater = 0, out_valid = 0.
- Reset mid-operation discards any in-flight sample. The first valid result after reset needs in_valid = 1 at a rising edge with rst_n = 1.
- Deassertion of rst_n is synchronous to clk in the surrounding design. The block needs no internal reset synchronizer.

## Test plan
- Reset: drive rst_n = 0 mid-cycle → all four outputs go to 0 immediately, with no clock edge needed. Release, and hold in_valid = 0 for 3 cycles → outputs remain 0.
- Exhaustive 1-bit unsigned sweep (casc_gt = casc_lt = 0, in_valid = 1), one pair per cycle, flags checked one cycle later:
  - A=0, B=0 → bothEqual = 1.
  - A=0, B=1 → B_greater = 1.
  - A=1, B=0 → A_greater = 1.
  - A=1, B=1 → bothEqual = 1.
  - Every cycle: exactly one flag high and out_valid = 1.
- Hold: after A=1, B=0 produces A_greater = 1, change to A=0, B=1 with in_valid = 0 → A_greater stays 1 for all idle cycles.
- Cascade with A=1, B=1:
  - casc_gt = 1 → A_greater = 1.
  - casc_lt = 1 → B_greater = 1.
  - casc_gt = casc_lt = 1 → A_greater = 1.
  - A=1, B=0 with casc_lt = 1 → A_greater = 1, because the local compare wins.
- SIGNED=1, WIDTH=1: A=1 (−1), B=0 → B_greater = 1. SIGNED=1, WIDTH=4: A=4'hF (−1), B=4'h1 → B_greater = 1. Unsigned, WIDTH=4, same operands → A_greater = 1.
- Async reset mid-stream: assert rst_n = 0 between edges while A_greater = 1 → all outputs drop to 0 at once. The next valid sample after release yields the correct result with 1-cycle latency.
